// File: rtl/clock_pkg.sv
// clock_pkg: shared 7-segment codes, time limits and digit index type for the clock display path.
package clock_pkg;
  typedef logic [1:0] digit_idx_t;
  localparam logic [5:0] HOUR_MAX   = 6'd23;
  localparam logic [5:0] MINUTE_MAX = 6'd59;
  localparam logic [6:0] SEG_0      = 7'b1000000;
  localparam logic [6:0] SEG_1      = 7'b1111001;
  localparam logic [6:0] SEG_2      = 7'b0100100;
  localparam logic [6:0] SEG_3      = 7'b0110000;
  localparam logic [6:0] SEG_4      = 7'b0011001;
  localparam logic [6:0] SEG_5      = 7'b0010010;
  localparam logic [6:0] SEG_6      = 7'b0000010;
  localparam logic [6:0] SEG_7      = 7'b1111000;
  localparam logic [6:0] SEG_8      = 7'b0000000;
  localparam logic [6:0] SEG_9      = 7'b0010000;
  localparam logic [6:0] SEG_DASH   = 7'b0111111;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    return d == 4'd0 ? SEG_0 : d == 4'd1 ? SEG_1 : d == 4'd2 ? SEG_2 :
           d == 4'd3 ? SEG_3 : d == 4'd4 ? SEG_4 : d == 4'd5 ? SEG_5 :
           d == 4'd6 ? SEG_6 : d == 4'd7 ? SEG_7 : d == 4'd8 ? SEG_8 :
           d == 4'd9 ? SEG_9 : SEG_BLANK;
  endfunction
endpackage

// File: rtl/display_scan_bin2bcd_6.sv
// bin2bcd_6: combinational 6-bit binary to two BCD digits using a compare chain instead of a divider.
module bin2bcd_6 (
  input  logic [5:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);
  always_comb begin
    tens_o = bin_i >= 6'd50 ? 4'd5 : bin_i >= 6'd40 ? 4'd4 : bin_i >= 6'd30 ? 4'd3 :
             bin_i >= 6'd20 ? 4'd2 : bin_i >= 6'd10 ? 4'd1 : 4'd0;
    ones_o = 4'(bin_i - 6'(tens_o) * 6'd10);
  end
endmodule

// File: rtl/display_scan.sv
// display_scan: multiplexes HH:MM onto four common-anode 7-segment digits from a per-frame input snapshot.
// Optional colon blinking on the decimal point of digit 2 is built when BLINK_COLON_EN is defined.
module display_scan
  import clock_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clock,
  input  logic       reset_display,
  input  logic       enable_display,
  input  logic [5:0] count_hour,
  input  logic [5:0] count_minute,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);
  localparam int DW = $clog2(SCAN_DIV);
  if (SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_bad_param
    $error("display_scan: SCAN_DIV and BLINK_DIV must be >= 2");
  end
  logic [DW-1:0] div_q, div_d;
  digit_idx_t idx_q, idx_d;
  logic [5:0] hour_q, hour_d, min_q, min_d;
  logic [3:0] an_q, an_d, h_t, h_o, m_t, m_o, digit;
  logic [6:0] seg_q, seg_d;
  logic tick, bad;
  bin2bcd_6 u_hour (.bin_i(hour_d), .tens_o(h_t), .ones_o(h_o));
  bin2bcd_6 u_min  (.bin_i(min_d),  .tens_o(m_t), .ones_o(m_o));
  // outputs are computed from next-state so the anode moves on the same edge as digit_idx
  always_comb begin
    tick   = div_q == DW'(SCAN_DIV - 1);
    div_d  = tick ? '0 : div_q + 1'b1;
    idx_d  = tick ? idx_q + 1'b1 : idx_q;
    hour_d = tick && idx_q == 2'd3 ? count_hour : hour_q;
    min_d  = tick && idx_q == 2'd3 ? count_minute : min_q;
    digit  = idx_d == 2'd0 ? m_o : idx_d == 2'd1 ? m_t : idx_d == 2'd2 ? h_o : h_t;
    bad    = idx_d[1] ? hour_d > HOUR_MAX : min_d > MINUTE_MAX;
    seg_d  = bad ? SEG_DASH : seg7(digit);
    an_d   = enable_display ? ~(4'b0001 << idx_d) : 4'b1111;
  end
  always_ff @(posedge clock) begin
    if (reset_display) begin
      div_q  <= '0;
      idx_q  <= '0;
      hour_q <= '0;
      min_q  <= '0;
      an_q   <= 4'b1111;
      seg_q  <= SEG_BLANK;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      hour_q <= hour_d;
      min_q  <= min_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end
  assign an  = an_q;
  assign seg = seg_q;
`ifdef BLINK_COLON_EN
  localparam int BW = $clog2(BLINK_DIV);
  logic [BW-1:0] blink_q, blink_d;
  logic colon_q, colon_d, dp_q, dp_d;
  always_comb begin
    blink_d = blink_q == BW'(BLINK_DIV - 1) ? '0 : blink_q + 1'b1;
    colon_d = blink_q == BW'(BLINK_DIV - 1) ? ~colon_q : colon_q;
    dp_d    = ~(enable_display && idx_d == 2'd2 && colon_d);
  end
  always_ff @(posedge clock) begin
    if (reset_display) begin
      blink_q <= '0;
      colon_q <= 1'b0;
      dp_q    <= 1'b1;
    end else begin
      blink_q <= blink_d;
      colon_q <= colon_d;
      dp_q    <= dp_d;
    end
  end
  assign dp = dp_q;
`else
  assign dp = 1'b1;
`endif
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed checks of scan order, snapshot coherence, dashes, blanking, reset and colon.
module tb_display_scan;
  import clock_pkg::*;
  logic       clock = 1'b0;
  logic       reset_display, enable_display;
  logic [5:0] count_hour, count_minute;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  int checks = 0;
  int failures = 0;
  display_scan #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clock(clock), .reset_display(reset_display), .enable_display(enable_display),
    .count_hour(count_hour), .count_minute(count_minute), .seg(seg), .an(an), .dp(dp)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask
  // called on the first cycle of a digit slot; checks it appears and is held 4 cycles
  task automatic slot(input string tag, input logic [3:0] ea, input logic [6:0] es);
    check({tag, "_an"}, an, ea);
    check({tag, "_seg"}, seg, es);
    cyc(3);
    check({tag, "_hold"}, an, ea);
    cyc(1);
  endtask
  initial begin
    logic [3:0] exp_an;
    logic       exp_dp, colon;
    reset_display = 1'b1;
    enable_display = 1'b1;
    count_hour = 6'd5;
    count_minute = 6'd5;
    cyc(3);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_dp", dp, 1'b1);
    reset_display = 1'b0;
    count_hour = 6'd13;
    count_minute = 6'd47;
    cyc(1);
    check("first_an", an, 4'b1110);
    check("first_seg", seg, SEG_0);
    cyc(3);
    slot("f0_d1", 4'b1101, SEG_0);
    slot("f0_d2", 4'b1011, SEG_0);
    slot("f0_d3", 4'b0111, SEG_0);
    slot("t13_d0", 4'b1110, SEG_7);
    slot("t13_d1", 4'b1101, SEG_4);
    slot("t13_d2", 4'b1011, SEG_3);
    slot("t13_d3", 4'b0111, SEG_1);
    count_hour = 6'd9;
    count_minute = 6'd59;
    slot("t13b_d0", 4'b1110, SEG_7);
    slot("t13b_d1", 4'b1101, SEG_4);
    slot("t13b_d2", 4'b1011, SEG_3);
    slot("t13b_d3", 4'b0111, SEG_1);
    slot("t09_d0", 4'b1110, SEG_9);
    count_hour = 6'd10;
    count_minute = 6'd0;
    slot("t09_d1", 4'b1101, SEG_5);
    slot("t09_d2", 4'b1011, SEG_9);
    slot("t09_d3", 4'b0111, SEG_0);
    slot("t10_d0", 4'b1110, SEG_0);
    slot("t10_d1", 4'b1101, SEG_0);
    slot("t10_d2", 4'b1011, SEG_0);
    slot("t10_d3", 4'b0111, SEG_1);
    count_hour = 6'd30;
    count_minute = 6'd60;
    slot("t10b_d0", 4'b1110, SEG_0);
    slot("t10b_d1", 4'b1101, SEG_0);
    slot("t10b_d2", 4'b1011, SEG_0);
    slot("t10b_d3", 4'b0111, SEG_1);
    count_hour = 6'd23;
    count_minute = 6'd59;
    slot("oor_d0", 4'b1110, SEG_DASH);
    slot("oor_d1", 4'b1101, SEG_DASH);
    slot("oor_d2", 4'b1011, SEG_DASH);
    slot("oor_d3", 4'b0111, SEG_DASH);
    slot("t23_d0", 4'b1110, SEG_9);
    slot("t23_d1", 4'b1101, SEG_5);
    slot("t23_d2", 4'b1011, SEG_3);
    slot("t23_d3", 4'b0111, SEG_2);
    slot("pre_blank_d0", 4'b1110, SEG_9);
    cyc(1);
    enable_display = 1'b0;
    cyc(1);
    check("blank_an", an, 4'b1111);
    check("blank_dp", dp, 1'b1);
    cyc(9);
    check("blank_hold_an", an, 4'b1111);
    enable_display = 1'b1;
    cyc(1);
    slot("resume_d0", 4'b1110, SEG_9);
    slot("resume_d1", 4'b1101, SEG_5);
    cyc(1);
    reset_display = 1'b1;
    cyc(1);
    check("mid_rst_an", an, 4'b1111);
    check("mid_rst_seg", seg, 7'b1111111);
    check("mid_rst_dp", dp, 1'b1);
    reset_display = 1'b0;
    for (int k = 1; k < 1000; k++) begin
      cyc(1);
      exp_an = ~(4'b0001 << ((k / 4) % 4));
      colon = ((k / 16) % 2) == 1;
`ifdef BLINK_COLON_EN
      exp_dp = !(exp_an == 4'b1011 && colon);
`else
      exp_dp = 1'b1 | colon;
`endif
      check($sformatf("run_an_k%0d", k), an, exp_an);
      check($sformatf("run_dp_k%0d", k), dp, exp_dp);
      if (k < 4) check($sformatf("restart_seg_k%0d", k), seg, SEG_0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/display_scan.md
Name: display_scan

Overview:
- Downstream consumer of the hour and minute counters.
- Takes binary count_hour (0..23) and count_minute (0..59), converts each to two BCD digits, and time-multiplexes four common-anode 7-segment digits.
- Sits between the counter chain and the board pins.
- Sequential content: a refresh divider, a digit-scan counter, a coherent input snapshot and registered outputs.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; must be >= 2.
- BLINK_DIV, 25000000, clock cycles per colon toggle; used only with the optional feature.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset_display  input  1  synchronous, active-high reset.
- enable_display  input  1  1 = scan normally; 0 = blank all digits.
- count_hour  input  6  binary hour from the hour counter.
- count_minute  input  6  binary minute from the minute counter.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  4  digit anodes, active-low; an[0] = rightmost digit.
- dp  output  1  decimal point / colon, active-low.

Behaviour:
- Clocking and reset:
  - Single clock; reset_display is synchronous and active-high.
  - While reset_display=1 at a rising edge: div_cnt=0, digit_idx=0, snapshot hour=0 and minute=0, an=4'b1111, seg=7'b1111111, dp=1.
- Refresh divider:
  - div_cnt counts 0..SCAN_DIV-1 and then wraps to 0.
  - tick=1 for one cycle when div_cnt==SCAN_DIV-1.
  - The divider always runs, including while enable_display=0.
- Digit scan:
  - On tick, digit_idx increments mod 4 (3 -> 0).
  - Digit mapping: idx0 = minute ones, idx1 = minute tens, idx2 = hour ones, idx3 = hour tens.
- Snapshot:
  - On a tick that moves digit_idx from 3 to 0, count_hour and count_minute are captured together.
  - All four digits of one frame therefore come from the same sample, so there is no tearing across a 59->00 carry.
  - The first frame after reset displays 00:00.
- BCD conversion:
  - Combinational from the snapshot.
  - tens = value/10 via a comparison chain (>=50, >=40, >=30, >=20, >=10); ones = value - 10*tens.
  - No divider operator.
- Out of range:
  - Snapshot hour > 23 shows both hour digits as "-" (seg=7'b0111111).
  - Snapshot minute > 59 does the same for both minute digits.
- Output registering:
  - an and seg are registered and update on the cycle after tick, giving a latency of 1 cycle from tick.
  - an drives exactly one 0, at position digit_idx.
- Blanking:
  - enable_display=0 forces an=4'b1111 and dp=1 on the next edge.
  - digit_idx and the snapshot keep advancing.
  - Re-enable resumes with the digit current at that time; no re-sync is needed.
- Leading zero: hour tens digit 0 is displayed as "0", not blanked.
- Segment encoding (active-low, standard):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Optional Feature:
- Macro: BLINK_COLON_EN.
- Defined:
  - A second counter toggles colon_state every BLINK_DIV cycles.
  - dp=~colon_state while digit_idx==2 and enable_display=1; otherwise dp=1.
  - Reset clears the counter and colon_state=0.
- Undefined: the counter is not built and dp is constant 1 except during reset, where it is also 1.

Decomposition:
- Shared package clock_pkg holds:
  - the 7-segment constants SEG_0..SEG_9, SEG_DASH and SEG_BLANK;
  - the limits HOUR_MAX=23 and MINUTE_MAX=59;
  - the digit index type (2-bit).
- One sub-module, bin2bcd_6: 6-bit binary in, 4-bit tens and 4-bit ones out, purely combinational.
  - Instantiated twice, once for hours and once for minutes.

Test Plan:
- All scenarios use SCAN_DIV=4 and BLINK_DIV=16.
- 1. Reset: hold reset_display=1 for 3 cycles with arbitrary inputs -> an=1111, seg=1111111, dp=1. After release with hour=13, minute=47:
  - the first frame shows 00:00;
  - the next frame drives an=1110 with seg=SEG_7, then an=1101/SEG_4, an=1011/SEG_3, an=0111/SEG_1.
  - Each digit is held 4 cycles and each an change occurs 1 cycle after tick.
- 2. Snapshot coherence: change hour 09->10 and minute 59->00 during a frame (digit_idx=1) -> the remainder of that frame still shows 09:59; the next frame shows 10:00.
- 3. Out of range: hour=30, minute=60 -> all four digits SEG_DASH. Then hour=23, minute=59 -> digits 9, 5, 3, 2 in scan order.
- 4. Blanking: drop enable_display for 10 cycles mid-frame -> an=1111 from the next edge. After re-enable, an resumes at the digit_idx implied by uninterrupted ticks.
- 5. Mid-operation reset: assert reset_display at digit_idx=2 -> next edge an=1111 and digit_idx=0. The scan restarts after exactly SCAN_DIV cycles from release.
- 6. BLINK_COLON_EN defined: dp is low only while an=1011, and only in alternate 16-cycle windows. Undefined: dp stays 1 for the whole 1000-cycle run.
